// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_D = 2'b01,
    GRANT_I = 2'b10
  } state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  // Map a winning port onto the grant state that serves it.
  function automatic state_t grant_state(input logic port);
    return (port == PORT_I) ? GRANT_I : GRANT_D;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin select: a lone requester wins, a tie goes to the
// port that was not served last. `last` only moves when a grant is taken.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,     // indexed by PORT_D / PORT_I
  input  logic       take,    // winner is being granted this edge
  output logic       valid,
  output logic       port
);

  logic last;

  // Winner selection from the current requests and the last-served port.
  always_comb begin
    valid = |req;
    port  = PORT_D;
    if (req[PORT_D] && req[PORT_I]) port = ~last;
    else if (req[PORT_I])           port = PORT_I;
  end

  // Remember who was served; resets to I so D wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              last <= PORT_I;
    else if (take && valid) last <= port;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one block memory between the I-cache (read-only) and the D-cache
// (read/write-back). One grant at a time, round-robin on ties, with a
// mandatory idle cycle between transfers so the memory sees its command drop.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  state_t            state, state_next;
  logic              started;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q, wr_q;
  logic              d_req, i_req;
  logic              grant_valid, grant_port, take, done;

  assign d_req = d_read | d_write;
  assign i_req = i_read;

  rr_arbiter2 u_rr (
    .clock (clock),
    .reset (reset),
    .req   ({i_req, d_req}),
    .take  (take),
    .valid (grant_valid),
    .port  (grant_port)
  );

  // A grant finishes once a full cycle has passed (covers memories that
  // raise busywait a cycle late) and the memory is no longer busy.
  assign done = (state != IDLE) && started && !mem_busywait;

  // Next-state: arbitrate only from IDLE, return to IDLE on completion.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          take       = 1'b1;
          state_next = grant_state(grant_port);
        end
      end
      GRANT_D, GRANT_I: if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // `started` is low on the grant edge and high from the second grant cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) started <= 1'b0;
    else       started <= (state != IDLE) && !done;
  end

  // Latch the winner's command/address/data on the grant edge; drop the
  // command on completion so the memory re-arms during the idle cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (take) begin
      if (grant_port == PORT_I) begin
        addr_q <= i_address;
        rd_q   <= 1'b1;
        wr_q   <= 1'b0;
      end else begin
        addr_q  <= d_address;
        wdata_q <= d_writedata;
        rd_q    <= d_read;              // read+write together counts as read
        wr_q    <= d_write & ~d_read;
      end
    end else if (done) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end
  end

  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;

  // Stall every requester except the owner during its completion cycle.
  assign d_busywait = d_req && !((state == GRANT_D) && started && !mem_busywait);
  assign i_busywait = i_req && !((state == GRANT_I) && started && !mem_busywait);

  assign d_readdata = mem_readdata;
  assign i_readdata = mem_readdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench: behavioural memory, transaction-level scoreboard,
// table of single transfers, hand sequences and randomized traffic.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          d_read = 1'b0, d_write = 1'b0, i_read = 1'b0;
  logic [AW-1:0] d_address = '0, i_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata, i_readdata, mem_writedata, mem_readdata;
  logic          d_busywait, i_busywait, mem_read, mem_write, mem_busywait;
  logic [AW-1:0] mem_address;

  always #5 clock = ~clock;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_readdata(d_readdata), .d_busywait(d_busywait),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
    .i_busywait(i_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5000000 ^ (32'(i) * 32'h00010203);
  endfunction

  // ---------------- behavioural memory ----------------
  logic [DW-1:0] memarr [0:63];
  int            m_lat  = 5;
  bit            m_late = 1'b0;
  int            mcnt;
  logic          mcmd;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  assign mcmd         = mem_read | mem_write;
  assign mem_busywait = mcmd && (m_late ? (mcnt >= 1 && mcnt <= m_lat) : (mcnt < m_lat));
  assign mem_readdata = memarr[mem_address];

  always @(posedge clock or posedge reset) begin
    if (reset)      mcnt <= 0;
    else if (!mcmd) mcnt <= 0;
    else            mcnt <= mcnt + 1;
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) memarr[i] <= init_word(i);
    end else if (pre_en) memarr[pre_addr] <= pre_data;
    else if (mem_write && !mem_busywait) memarr[mem_address] <= mem_writedata;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] model_mem [0:63];
  bit            mon_en = 1'b1;
  bit            m_last;
  bit            p_cmd, p_dreq, p_ireq;
  bit            own, own_wr, exp_port, exp_wr, cmd;
  int            k, len, gap, last_len, last_gap;
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] exp_addr;
  logic [7:0]    grant_hist = '0;
  int            grant_cnt = 0;

  always @(negedge clock) begin
    cmd = mem_read | mem_write;
    if (reset) begin
      for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
      m_last = PORT_I;
      k = 0; gap = 0;
    end else begin
      if (pre_en) model_mem[pre_addr] = pre_data;
      if (mon_en) begin
        len = m_late ? m_lat + 2 : (m_lat < 1 ? 2 : m_lat + 1);
        if (cmd && !p_cmd) begin
          chk("grant_has_request", {31'b0, p_dreq | p_ireq}, 32'd1);
          exp_port = (p_dreq && p_ireq) ? ~m_last : (p_dreq ? PORT_D : PORT_I);
          exp_wr   = (exp_port == PORT_D) && d_write && !d_read;
          exp_addr = (exp_port == PORT_D) ? d_address : i_address;
          chk("grant_port", {31'b0, mem_address[5]}, {31'b0, exp_port});
          chk("grant_address", mem_address, exp_addr);
          chk("grant_mem_write", mem_write, exp_wr);
          chk("grant_mem_read", mem_read, !exp_wr);
          if (exp_wr) begin
            chk("grant_writedata", mem_writedata, d_writedata);
            model_mem[exp_addr] = d_writedata;
          end
          exp_rd     = model_mem[exp_addr];
          own        = exp_port;
          own_wr     = exp_wr;
          m_last     = exp_port;
          last_gap   = gap;
          grant_hist = {grant_hist[6:0], exp_port};
          grant_cnt++;
          k = 0;
        end
        if (cmd) begin
          k++;
          chk("cmd_overrun", {31'b0, k > len}, 32'd0);
          if (own == PORT_D) begin
            chk("owner_d_busywait", d_busywait, k != len);
            chk("waiting_i_busywait", i_busywait, i_read);
          end else begin
            chk("owner_i_busywait", i_busywait, k != len);
            chk("waiting_d_busywait", d_busywait, d_read | d_write);
          end
          if (k == len && !own_wr)
            chk("readdata", (own == PORT_D) ? d_readdata : i_readdata, exp_rd);
          gap = 0;
        end else begin
          if (p_cmd) begin
            chk("cmd_length", k, len);
            last_len = k;
          end
          chk("idle_d_busywait", d_busywait, d_read | d_write);
          chk("idle_i_busywait", i_busywait, i_read);
          gap++;
        end
      end
    end
    p_cmd  = cmd;
    p_dreq = d_read | d_write;
    p_ireq = i_read;
  end

  // ---------------- requester drivers (called at posedge+1) ----------------
  task automatic d_txn(input int op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       output logic [DW-1:0] rd);
    int n = 0;
    d_address = a; d_writedata = wd;
    d_read = (op != 1); d_write = (op != 0);
    while (n < 200) begin
      @(negedge clock);
      if (!d_busywait) break;
      n++;
    end
    chk("d_txn_timeout", {31'b0, n < 200}, 32'd1);
    rd = d_readdata;
    @(posedge clock); #1;
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic i_txn(input logic [AW-1:0] a, output logic [DW-1:0] rd);
    int n = 0;
    i_address = a; i_read = 1'b1;
    while (n < 200) begin
      @(negedge clock);
      if (!i_busywait) break;
      n++;
    end
    chk("i_txn_timeout", {31'b0, n < 200}, 32'd1);
    rd = i_readdata;
    @(posedge clock); #1;
    i_read = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // ---------------- table of single transfers ----------------
  typedef struct {
    bit            is_i;
    int            op;       // 0 read, 1 write, 2 read+write (treated as read)
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    bit            late;
    bit            pre;      // preload exp_rd into memory first
    int            exp_len;  // cycles mem command stays high
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t          vec [7];
  logic [DW-1:0] rd_d, rd_i;
  int            c0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{0, 0, 6'h0A, 32'h0,        5, 0, 1, 6, 32'hDEADBEEF};
    vec[1] = '{1, 0, 6'h21, 32'h0,        2, 0, 1, 3, 32'hCAFEF00D};
    vec[2] = '{0, 1, 6'h03, 32'h12345678, 3, 0, 0, 4, 32'h0};
    vec[3] = '{0, 0, 6'h03, 32'h0,        1, 0, 0, 2, 32'h12345678};
    vec[4] = '{1, 0, 6'h3F, 32'h0,        5, 1, 1, 7, 32'hA5A5A5A5};
    vec[5] = '{0, 1, 6'h10, 32'h0BADC0DE, 2, 1, 0, 4, 32'h0};
    vec[6] = '{0, 2, 6'h0A, 32'h0,        2, 0, 0, 3, 32'hDEADBEEF};

    // Reset state; busywait follows the request even under reset.
    #2 d_read = 1'b1;
    @(posedge clock); #1;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 6'h00);
    chk("rst_mem_writedata", mem_writedata, 32'h0);
    chk("rst_d_busywait_req", d_busywait, 1'b1);
    chk("rst_i_busywait", i_busywait, 1'b0);
    d_read = 1'b0; #1;
    chk("rst_d_busywait_noreq", d_busywait, 1'b0);
    @(posedge clock); #1 reset = 1'b0;
    idle(1);

    // Table: one transfer at a time from idle.
    for (int v = 0; v < 7; v++) begin
      m_lat = vec[v].lat; m_late = vec[v].late;
      if (vec[v].pre) preload(vec[v].addr, vec[v].exp_rd);
      if (vec[v].is_i) i_txn(vec[v].addr, rd_i);
      else             d_txn(vec[v].op, vec[v].addr, vec[v].wdata, rd_d);
      idle(2);
      chk($sformatf("tbl%0d_len", v), last_len, vec[v].exp_len);
      if (vec[v].op == 1) chk($sformatf("tbl%0d_memword", v), memarr[vec[v].addr], vec[v].wdata);
      else chk($sformatf("tbl%0d_rdata", v), vec[v].is_i ? rd_i : rd_d, vec[v].exp_rd);
    end

    // Simultaneous D and I right after reset: D first, one idle cycle, then I.
    m_lat = 3; m_late = 0;
    do_reset();
    c0 = grant_cnt;
    fork
      d_txn(0, 6'h0A, 32'h0, rd_d);
      i_txn(6'h21, rd_i);
    join
    idle(2);
    chk("tie_grant_count", grant_cnt - c0, 2);
    chk("tie_order_D_then_I", grant_hist[1:0], 2'b01);
    chk("tie_idle_gap", last_gap, 1);

    // D write-back while I waits; I gets no write command.
    c0 = grant_cnt;
    fork
      d_txn(1, 6'h03, 32'h12345678, rd_d);
      i_txn(6'h22, rd_i);
    join
    idle(2);
    chk("wb_order", grant_hist[1:0], 2'b01);
    chk("wb_memword", memarr[6'h03], 32'h12345678);
    chk("wb_i_rdata", rd_i, init_word(6'h22));

    // Continuous requests from both ports alternate strictly.
    c0 = grant_cnt;
    fork
      begin d_txn(0, 6'h05, 32'h0, rd_d); d_txn(0, 6'h06, 32'h0, rd_d); end
      begin i_txn(6'h25, rd_i); i_txn(6'h26, rd_i); end
    join
    idle(2);
    chk("rr_grant_count", grant_cnt - c0, 4);
    chk("rr_order_DIDI", grant_hist[3:0], 4'b0101);

    // Reset during cycle 3 of an I grant, then I re-granted after release.
    mon_en = 1'b0; m_lat = 5; m_late = 0;
    fork
      i_txn(6'h2A, rd_i);
      begin
        int n = 0;
        while (n < 50) begin
          @(negedge clock);
          if (mem_read) break;
          n++;
        end
        chk("rst_mid_grant_seen", {31'b0, n < 50}, 32'd1);
        @(posedge clock); @(posedge clock); #2 reset = 1'b1;
        #1;
        chk("rst_mid_mem_read", mem_read, 1'b0);
        chk("rst_mid_state", dut.state, IDLE);
        chk("rst_mid_i_busywait", i_busywait, 1'b1);
        @(posedge clock); #1 reset = 1'b0;
      end
    join
    chk("rst_regrant_rdata", rd_i, init_word(6'h2A));
    idle(2);
    mon_en = 1'b1;
    idle(1);

    // Randomized traffic against the scoreboard, several memory timings.
    for (int ph = 0; ph < 4; ph++) begin
      m_lat  = (ph == 0) ? 1 : (ph == 1) ? 3 : (ph == 2) ? 2 : 4;
      m_late = (ph >= 2);
      fork
        for (int t = 0; t < 8; t++) begin
          idle($urandom_range(0, 2));
          d_txn($urandom_range(0, 2), 6'($urandom_range(0, 31)), $urandom, rd_d);
        end
        for (int t = 0; t < 8; t++) begin
          idle($urandom_range(0, 2));
          i_txn(6'($urandom_range(32, 63)), rd_i);
        end
      join
      idle(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
